nrs_pilot_extractor: RTL and testbench

NRS_PILOT_EXTRACTOR -- requirements
Module: nrs_pilot_extractor

---
 rtl/nrs_pilot_extractor_pkg.sv | 24 ++
 rtl/nrs_pilot_extractor.sv | 85 ++++++++
 tb/tb_nrs_pilot_extractor.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nrs_pilot_extractor_pkg.sv
// Shared constants and FSM encoding for NRS pilot extraction.
// Holds the two NRS OFDM symbols, the pilot count and the subcarriers per resource block.
package nrs_pilot_extractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam int NRS_SYM_A = 5;
  localparam int NRS_SYM_B = 6;
  localparam int NUM_NRS   = 4;
  localparam int SC_PER_RB = 12;

  localparam logic [1:0] LAST_IDX = 2'(NUM_NRS - 1);

  // Pilots 0,1 sit in the first NRS symbol, pilots 2,3 in the second.
  function automatic logic [3:0] nrs_sym(input logic [1:0] cnt);
    return cnt[1] ? 4'(NRS_SYM_B) : 4'(NRS_SYM_A);
  endfunction

endpackage

// File: rtl/nrs_pilot_extractor.sv
// Reads the four NRS pilot REs of one subframe from the resource grid and
// streams them to channel estimation over a valid/ready handshake.
module nrs_pilot_extractor
  import nrs_pilot_extractor_pkg::*;
#(
  parameter int DW      = 16,
  parameter int GRID_AW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8:0]           N_cell_ID,
  output logic [8:0]           cell_id_out,
  output logic [1:0]           est_rd_addr,
  input  logic [3:0]           index_demap,
  output logic                 grid_rd_en,
  output logic [GRID_AW-1:0]   grid_rd_addr,
  input  logic [2*DW-1:0]      grid_rd_data,
  output logic [2*DW-1:0]      pilot_data,
  output logic [1:0]           pilot_idx,
  output logic                 pilot_last,
  output logic                 pilot_valid,
  input  logic                 pilot_ready,
  output logic                 busy,
  output logic                 done
);

  state_t     state, state_nx;
  logic [1:0] cnt;
  logic       accept;
  logic       handshake;

  assign accept    = (state == ST_IDLE) && start;
  assign handshake = (state == ST_OUT) && pilot_ready;

  // NOTE: every variable driven here gets its default before the case, so no latch can form.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RD;
      ST_RD:   state_nx = ST_CAP;
      ST_CAP:  state_nx = ST_OUT;
      ST_OUT:  if (pilot_ready) state_nx = (cnt == LAST_IDX) ? ST_IDLE : ST_RD;
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cell_id_out <= '0;
      done        <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= handshake && (cnt == LAST_IDX);
      if (accept) begin
        cnt         <= '0;
        cell_id_out <= N_cell_ID;
      end else if (handshake && (cnt != LAST_IDX)) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  // NOTE: the output data register is reset so a mid-run reset leaves no stale pilot visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pilot_data <= '0;
      pilot_idx  <= '0;
    end else if (state == ST_CAP) begin
      pilot_data <= grid_rd_data;
      pilot_idx  <= cnt;
    end
  end

  assign est_rd_addr  = cnt;
  assign grid_rd_en   = (state == ST_RD);
  assign grid_rd_addr = GRID_AW'({nrs_sym(cnt), index_demap});
  assign pilot_valid  = (state == ST_OUT);
  assign pilot_last   = pilot_valid && (pilot_idx == LAST_IDX);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_nrs_pilot_extractor.sv
// Scoreboard bench for nrs_pilot_extractor with a behavioural index generator and grid memory.
module tb_nrs_pilot_extractor;
  import nrs_pilot_extractor_pkg::*;

  localparam int DW = 16;
  localparam int GRID_AW = 8;

  typedef struct {
    logic [2*DW-1:0] data;
    logic [1:0]      idx;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, pilot_ready;
  logic [8:0] N_cell_ID, cell_id_out;
  logic [1:0] est_rd_addr, pilot_idx;
  logic [3:0] index_demap;
  logic grid_rd_en, pilot_last, pilot_valid, busy, done;
  logic [GRID_AW-1:0] grid_rd_addr;
  logic [2*DW-1:0] grid_rd_data, pilot_data;

  int n_checks = 0;
  int n_fail = 0;
  int ncyc = 0;
  int start_ncyc = 0;

  logic [GRID_AW-1:0] addr_q[$];
  exp_t exp_q[$];
  int rd_times[$];
  int pv_times[$];
  int done_times[$];
  bit held_valid = 1'b0;
  logic [2*DW-1:0] held_data;
  logic [1:0] held_idx;

  nrs_pilot_extractor #(.DW(DW), .GRID_AW(GRID_AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .N_cell_ID(N_cell_ID),
    .cell_id_out(cell_id_out), .est_rd_addr(est_rd_addr), .index_demap(index_demap),
    .grid_rd_en(grid_rd_en), .grid_rd_addr(grid_rd_addr), .grid_rd_data(grid_rd_data),
    .pilot_data(pilot_data), .pilot_idx(pilot_idx), .pilot_last(pilot_last),
    .pilot_valid(pilot_valid), .pilot_ready(pilot_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  function automatic int base_sc(input int k);
    case (k)
      0: return 0;
      1: return 6;
      2: return 3;
      default: return 9;
    endcase
  endfunction

  function automatic logic [2*DW-1:0] re_val(input logic [GRID_AW-1:0] a);
    return {8'hA5, a, a, 8'h5A};
  endfunction

  // Index generator model: v_shift = cell_id mod 6 applied to the base pattern.
  assign index_demap = 4'((base_sc(int'(est_rd_addr)) + int'(cell_id_out) % 6) % SC_PER_RB);

  // Grid memory: data valid one cycle after the read strobe, junk otherwise.
  always @(posedge clk)
    grid_rd_data <= grid_rd_en ? re_val(grid_rd_addr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_run(input logic [8:0] cid);
    for (int k = 0; k < NUM_NRS; k++) begin
      logic [3:0] sym;
      logic [3:0] sc;
      logic [GRID_AW-1:0] a;
      exp_t e;
      sym = (k < 2) ? 4'(NRS_SYM_A) : 4'(NRS_SYM_B);
      sc  = 4'((base_sc(k) + int'(cid) % 6) % SC_PER_RB);
      a   = {sym, sc};
      addr_q.push_back(a);
      e.data = re_val(a);
      e.idx  = 2'(k);
      e.last = (k == NUM_NRS - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [8:0] cid, input bit accepted);
    @(posedge clk); #1;
    start = 1'b1;
    N_cell_ID = cid;
    start_ncyc = ncyc;
    if (accepted) push_run(cid);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int s, input int n, input int lat);
    for (int i = 0; i < 100 && done_times.size() < n; i++) @(posedge clk);
    if (done_times.size() < n) check({tag, "_timeout"}, 64'(done_times.size()), 64'(n));
    else check({tag, "_lat"}, 64'(done_times[n-1] - s), 64'(lat));
  endtask

  task automatic clear_logs();
    rd_times.delete();
    pv_times.delete();
    done_times.delete();
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (grid_rd_en) begin
        rd_times.push_back(ncyc);
        if (addr_q.size() == 0) check("rd_unexpected", grid_rd_en, 1'b0);
        else check("rd_addr", grid_rd_addr, addr_q.pop_front());
      end
      if (pilot_valid) begin
        if (held_valid) begin
          check("hold_data", pilot_data, held_data);
          check("hold_idx", pilot_idx, held_idx);
        end else begin
          pv_times.push_back(ncyc);
        end
        if (pilot_ready) begin
          held_valid = 1'b0;
          if (exp_q.size() == 0) begin
            check("pilot_unexpected", pilot_valid, 1'b0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pilot_data", pilot_data, e.data);
            check("pilot_idx", pilot_idx, e.idx);
            check("pilot_last", pilot_last, e.last);
            check("est_rd_addr", est_rd_addr, e.idx);
          end
        end else begin
          held_valid = 1'b1;
          held_data = pilot_data;
          held_idx = pilot_idx;
          check("stall_rd_en", grid_rd_en, 1'b0);
        end
      end
      if (done) done_times.push_back(ncyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2;
    rst_n = 1'b0; start = 1'b0; pilot_ready = 1'b1; N_cell_ID = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", pilot_valid, 1'b0);
    check("rst_rd_en", grid_rd_en, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cell", cell_id_out, 9'd0);
    check("rst_data", pilot_data, '0);
    rst_n = 1'b1;

    // Cell 0, ready high: latency and read pattern.
    clear_logs();
    pulse_start(9'd0, 1'b1); s1 = start_ncyc;
    check("busy_run", busy, 1'b1);
    wait_done("c0_done", s1, 1, 13);
    check("c0_first_rd", 64'(rd_times[0] - s1), 64'd1);
    check("c0_first_valid", 64'(pv_times[0] - s1), 64'd3);
    check("c0_sb_empty", 64'(exp_q.size()), 64'd0);
    #1 check("c0_busy_idle", busy, 1'b0);

    // Cell 503: v_shift 5.
    clear_logs();
    pulse_start(9'd503, 1'b1); s1 = start_ncyc;
    check("c503_cell", cell_id_out, 9'd503);
    wait_done("c503_done", s1, 1, 13);
    check("c503_sb_empty", 64'(exp_q.size()), 64'd0);

    // Stall pilot 1 for five cycles.
    clear_logs();
    pulse_start(9'd42, 1'b1); s1 = start_ncyc;
    repeat (5) @(posedge clk);
    #1 pilot_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 pilot_ready = 1'b1;
    wait_done("stall_done", s1, 1, 18);
    check("stall_sb_empty", 64'(exp_q.size()), 64'd0);

    // Start during CAP with another cell ID must be ignored.
    clear_logs();
    pulse_start(9'd77, 1'b1); s1 = start_ncyc;
    pulse_start(9'd300, 1'b0);
    check("ign_cell", cell_id_out, 9'd77);
    wait_done("ign_done", s1, 1, 13);
    repeat (5) @(posedge clk);
    check("ign_done_count", 64'(done_times.size()), 64'd1);
    check("ign_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset during OUT of pilot 2.
    clear_logs();
    pulse_start(9'd100, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_valid", pilot_valid, 1'b1);
    check("pre_rst_idx", pilot_idx, 2'd2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", pilot_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_idx", pilot_idx, 2'd0);
    check("arst_data", pilot_data, '0);
    check("arst_cell", cell_id_out, 9'd0);
    check("arst_cnt", est_rd_addr, 2'd0);
    check("arst_last", pilot_last, 1'b0);
    check("arst_rd_en", grid_rd_en, 1'b0);
    check("arst_done", done, 1'b0);
    addr_q.delete();
    exp_q.delete();
    held_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_done", 64'(done_times.size()), 64'd0);
    check("post_rst_busy", busy, 1'b0);
    pulse_start(9'd7, 1'b1); s1 = start_ncyc;
    wait_done("rerun_done", s1, 1, 13);
    check("rerun_sb_empty", 64'(exp_q.size()), 64'd0);

    // Start coincident with done.
    clear_logs();
    pulse_start(9'd11, 1'b1); s1 = start_ncyc;
    repeat (11) @(posedge clk);
    pulse_start(9'd250, 1'b1); s2 = start_ncyc;
    check("b2b_start_at_done", 64'(s2 - s1), 64'd13);
    wait_done("b2b_done2", s2, 2, 13);
    check("b2b_done1_lat", 64'(done_times[0] - s1), 64'd13);
    check("b2b_rd2", 64'(rd_times[4] - s2), 64'd1);
    repeat (5) @(posedge clk);
    check("b2b_done_count", 64'(done_times.size()), 64'd2);
    check("b2b_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
